fir_channel_sched: RTL
======================

// Module: fir_channel_sched
// PURPOSE
// Time-shares one Avalon-ST FIR filter between the left and right audio channels.
// - Takes ADC samples from the audio core's left/right output streams.
// - Issues them, round-robin, to the single FIR.
// - Tags each issued sample with its channel and routes the FIR result back to that
//   channel's DAC input stream.
// - The FIR has no backpressure, so samples are issued only when the result is
//   guaranteed a landing slot.
// PARAMETERS
// IN_W       32    audio sample width (audio core streams); FIR_OUT_W must equal IN_W
// FIR_IN_W   16    FIR input width; FIR gets sample[IN_W-1 -: FIR_IN_W] (MSB slice)
// FIR_OUT_W  32    FIR output width
// TIMEOUT    1024  cycles without any FIR result while results are outstanding -> flush
// PORTS
// clk_clk        in   1          system clock
// reset_reset_n  in   1          async active-low reset
// l_in_data      in   IN_W       left ADC sample (from audio left_output)
// l_in_valid     in   1          left sample valid
// l_in_ready     out  1          left sample accepted when valid&ready
// r_in_data      in   IN_W       right ADC sample
// r_in_valid     in   1
// r_in_ready     out  1
// l_out_data     out  IN_W       filtered left sample (to audio left_input)
// l_out_valid    out  1
// l_out_ready    in   1
// r_out_data     out  IN_W       filtered right sample
// r_out_valid    out  1
// r_out_ready    in   1
// fir_in_data    out  FIR_IN_W   sample to FIR
// fir_in_valid   out  1          one-cycle issue strobe
// fir_in_error   out  2          tied 2'b00
// fir_out_data   in   FIR_OUT_W  FIR result
// fir_out_valid  in   1          result strobe; results return in issue order
// fir_out_error  in   2          FIR error code
// clr_status     in   1          sync clear of sticky flags
// err_sticky     out  1          FIR error, or result with no outstanding tag, seen
// timeout_sticky out  1          timeout flush occurred
// BEHAVIOUR
// - Reset: all outputs 0 (incl. *_ready, fir_in_valid, stickies); tags, pend flags, rr=L, timer cleared.
// - Per channel: pend_c is set on issue and cleared on its result. Channel c is eligible
//   when !pend_c && !c_out_valid. At most one sample per channel is in flight.
// - Arbitration (combinational ready):
//   - Both valid and eligible: grant goes to rr. rr flips to the other channel after any grant.
//   - Only one valid and eligible: that channel is granted.
//   - At most one grant per cycle.
// - Issue: on grant handshake at cycle N, fir_in_data/fir_in_valid are registered and valid
//   in cycle N+1 for exactly 1 cycle. The channel tag is pushed to a 2-entry in-order tag FIFO.
// - Result: on fir_out_valid with tag FIFO non-empty:
//   - Pop the tag.
//   - Load fir_out_data into that channel's out register; c_out_valid=1 the next cycle.
//   - Clear pend_c.
//   - Push and pop in the same cycle are both honoured.
// - Output: c_out_valid holds, with data stable, until c_out_ready. It clears in the cycle
//   after the handshake. Output valid and ready are independent.
// - fir_out_valid with tag FIFO empty: result dropped, err_sticky=1.
// - fir_out_error != 0 with valid: data still routed, err_sticky=1.
// - Timer: counts cycles while the tag FIFO is non-empty; resets to 0 on any fir_out_valid
//   or when the FIFO is empty.
// - Timeout: at TIMEOUT-1 the tag FIFO and all pend flags are flushed and timeout_sticky=1.
//   Out registers are untouched. Late results then hit the empty-FIFO rule.
// - clr_status: clears the stickies next cycle. A same-cycle set wins over clr.
// - Async reset mid-transfer: everything clears immediately. In-flight FIR results after
//   release are dropped via the empty-FIFO rule.
// CONFIGURATION
// FIR_SCHED_BYPASS_EN defined: adds input port `bypass` (1 bit).
// - While bypass=1: no FIR issue. A granted sample goes straight to its channel out register,
//   unmodified, 1 cycle after the handshake. Eligibility ignores pend.
// - Results for tags already in flight are still routed normally.
// Not defined: no `bypass` port; all samples go through the FIR.
// TESTING
// 1. L valid only, 0x12345678; FIR model returns 0xAAAA0001 after 5 cycles
//    -> fir_in_data=0x1234 at N+1, l_out_data=0xAAAA0001, r_out_valid stays 0.
// 2. L and R valid in the same cycle, rr=L -> L issued first, R issued on the next eligible
//    cycle; results routed to the correct channels in order; rr ends at L.
// 3. l_out_ready=0 with a result held -> l_in_ready stays 0 (no new L issue); R continues;
//    l_out_data stable until ready.
// 4. Issue L, FIR model never responds -> flush at cycle TIMEOUT, timeout_sticky=1,
//    l_in_ready re-asserts; a late result -> err_sticky=1, dropped.
// 5. fir_out_error=2'b01 with a valid result -> data delivered, err_sticky=1;
//    clr_status -> 0 next cycle.
// 6. reset_reset_n low mid-flight -> all outputs 0 asynchronously; a post-reset stray
//    result is dropped.

Source files
------------

// File: rtl/fir_channel_sched.sv
// ----------------------------------------------------------------------------
// fir_channel_sched
//
// Shares one Avalon-ST FIR filter between the left and right audio channels.
// ADC samples from the audio core's left/right streams are arbitrated
// round-robin and issued to the FIR. Each issued sample's channel is tagged,
// and the tag steers the matching FIR result into that channel's DAC-side out
// register. The FIR cannot be stalled, so a channel is only issued when its
// out register is empty and it has nothing in flight. The result therefore
// always has somewhere to land.
//
// Parameters
//   IN_W       audio sample width (FIR_OUT_W must equal IN_W)
//   FIR_IN_W   FIR input width; the FIR receives the MSB slice of the sample
//   FIR_OUT_W  FIR output width
//   TIMEOUT    idle cycles with results outstanding before the tags are flushed
//
// Ports
//   clk_clk, reset_reset_n          clock, async active-low reset
//   l_in_* / r_in_*                 ADC sample streams (valid/ready/data)
//   l_out_* / r_out_*               filtered sample streams to the DAC side
//   fir_in_data/valid/error         issue to FIR (one-cycle strobe, error tied 0)
//   fir_out_data/valid/error        FIR results, returned in issue order
//   clr_status                      synchronous clear of the sticky flags
//   err_sticky                      FIR error code or untagged result seen
//   timeout_sticky                  timeout flush occurred
//   bypass                          (FIR_SCHED_BYPASS_EN only) route samples
//                                   straight to the out registers, skipping the FIR
//
// Build option: define FIR_SCHED_BYPASS_EN to add the bypass port.
// ----------------------------------------------------------------------------
module fir_channel_sched #(
    parameter int IN_W      = 32,
    parameter int FIR_IN_W  = 16,
    parameter int FIR_OUT_W = 32,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,

    input  logic [IN_W-1:0]      l_in_data,
    input  logic                 l_in_valid,
    output logic                 l_in_ready,
    input  logic [IN_W-1:0]      r_in_data,
    input  logic                 r_in_valid,
    output logic                 r_in_ready,

    output logic [IN_W-1:0]      l_out_data,
    output logic                 l_out_valid,
    input  logic                 l_out_ready,
    output logic [IN_W-1:0]      r_out_data,
    output logic                 r_out_valid,
    input  logic                 r_out_ready,

    output logic [FIR_IN_W-1:0]  fir_in_data,
    output logic                 fir_in_valid,
    output logic [1:0]           fir_in_error,
    input  logic [FIR_OUT_W-1:0] fir_out_data,
    input  logic                 fir_out_valid,
    input  logic [1:0]           fir_out_error,

`ifdef FIR_SCHED_BYPASS_EN
    input  logic                 bypass,
`endif
    input  logic                 clr_status,
    output logic                 err_sticky,
    output logic                 timeout_sticky
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic {
        CH_L = 1'b0,
        CH_R = 1'b1
    } chan_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    chan_e                rr_q, rr_d;
    logic                 pend_l_q, pend_l_d;
    logic                 pend_r_q, pend_r_d;
    chan_e                tag0_q, tag0_d;      // FIFO head
    chan_e                tag1_q, tag1_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [FIR_IN_W-1:0]  fir_data_q, fir_data_d;
    logic                 fir_valid_q, fir_valid_d;
    logic [IN_W-1:0]      l_data_q, l_data_d;
    logic                 l_valid_q, l_valid_d;
    logic [IN_W-1:0]      r_data_q, r_data_d;
    logic                 r_valid_q, r_valid_d;
    logic                 err_q, err_d;
    logic                 tmo_q, tmo_d;

    // ------------------------------------------------------------------
    // Arbitration and result decode
    // ------------------------------------------------------------------
    logic  byp;
    logic  res_pop, res_l, res_r;
    logic  elig_l, elig_r;
    logic  req_l, req_r;
    logic  grant_l, grant_r;
    logic  issue;
    logic  timeout_hit;
    logic  err_set;
    chan_e push_tag;

`ifdef FIR_SCHED_BYPASS_EN
    assign byp = bypass;
`else
    assign byp = 1'b0;
`endif

    assign res_pop = fir_out_valid && (cnt_q != 2'd0);
    assign res_l   = res_pop && (tag0_q == CH_L);
    assign res_r   = res_pop && (tag0_q == CH_R);

    // In bypass mode pend is ignored. A result landing in this channel's
    // out register this same cycle still blocks the grant, so the two
    // writes never collide.
    assign elig_l = !l_valid_q && (byp ? !res_l : !pend_l_q);
    assign elig_r = !r_valid_q && (byp ? !res_r : !pend_r_q);

    // Gating with reset keeps ready low while reset is asserted.
    assign req_l = reset_reset_n && l_in_valid && elig_l;
    assign req_r = reset_reset_n && r_in_valid && elig_r;

    assign grant_l = req_l && (!req_r || (rr_q == CH_L));
    assign grant_r = req_r && (!req_l || (rr_q == CH_R));

    assign issue    = (grant_l || grant_r) && !byp;
    assign push_tag = grant_l ? CH_L : CH_R;

    assign timeout_hit = (cnt_q != 2'd0) && !fir_out_valid
                         && (timer_q == TW'(TIMEOUT - 1));

    assign err_set = fir_out_valid && ((cnt_q == 2'd0) || (fir_out_error != 2'b00));

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        rr_d        = rr_q;
        pend_l_d    = pend_l_q;
        pend_r_d    = pend_r_q;
        tag0_d      = tag0_q;
        tag1_d      = tag1_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        fir_data_d  = fir_data_q;
        fir_valid_d = issue;
        l_data_d    = l_data_q;
        l_valid_d   = l_valid_q;
        r_data_d    = r_data_q;
        r_valid_d   = r_valid_q;
        err_d       = err_q;
        tmo_d       = tmo_q;

        // Round-robin pointer moves away from whichever channel was granted.
        if (grant_l) begin
            rr_d = CH_R;
        end else if (grant_r) begin
            rr_d = CH_L;
        end

        if (issue) begin
            fir_data_d = grant_l ? l_in_data[IN_W-1 -: FIR_IN_W]
                                 : r_in_data[IN_W-1 -: FIR_IN_W];
        end

        // Out registers: handshake drains, a new load (result or bypass) wins.
        if (l_valid_q && l_out_ready) begin
            l_valid_d = 1'b0;
        end
        if (r_valid_q && r_out_ready) begin
            r_valid_d = 1'b0;
        end
        if (res_l) begin
            l_valid_d = 1'b1;
            l_data_d  = fir_out_data;
        end
        if (res_r) begin
            r_valid_d = 1'b1;
            r_data_d  = fir_out_data;
        end
        if (byp && grant_l) begin
            l_valid_d = 1'b1;
            l_data_d  = l_in_data;
        end
        if (byp && grant_r) begin
            r_valid_d = 1'b1;
            r_data_d  = r_in_data;
        end

        // Pend flags: the flush is applied before a same-cycle issue, so a
        // sample granted in the flush cycle keeps its pend flag and tag.
        if (timeout_hit) begin
            pend_l_d = 1'b0;
            pend_r_d = 1'b0;
        end
        if (res_l) begin
            pend_l_d = 1'b0;
        end
        if (res_r) begin
            pend_r_d = 1'b0;
        end
        if (issue && grant_l) begin
            pend_l_d = 1'b1;
        end
        if (issue && grant_r) begin
            pend_r_d = 1'b1;
        end

        // Two-entry tag FIFO held as a shift register (tag0 is the head).
        if (timeout_hit) begin
            cnt_d = 2'd0;
        end else if (res_pop) begin
            tag0_d = tag1_q;
            cnt_d  = cnt_q - 2'd1;
        end
        if (issue) begin
            if (cnt_d == 2'd0) begin
                tag0_d = push_tag;
            end else begin
                tag1_d = push_tag;
            end
            cnt_d = cnt_d + 2'd1;
        end

        if ((cnt_q == 2'd0) || fir_out_valid || timeout_hit) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        // Sticky flags: a same-cycle set takes priority over the clear.
        if (err_set) begin
            err_d = 1'b1;
        end else if (clr_status) begin
            err_d = 1'b0;
        end
        if (timeout_hit) begin
            tmo_d = 1'b1;
        end else if (clr_status) begin
            tmo_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rr_q        <= CH_L;
            pend_l_q    <= 1'b0;
            pend_r_q    <= 1'b0;
            tag0_q      <= CH_L;
            tag1_q      <= CH_L;
            cnt_q       <= '0;
            timer_q     <= '0;
            fir_data_q  <= '0;
            fir_valid_q <= 1'b0;
            l_data_q    <= '0;
            l_valid_q   <= 1'b0;
            r_data_q    <= '0;
            r_valid_q   <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            pend_l_q    <= pend_l_d;
            pend_r_q    <= pend_r_d;
            tag0_q      <= tag0_d;
            tag1_q      <= tag1_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            fir_data_q  <= fir_data_d;
            fir_valid_q <= fir_valid_d;
            l_data_q    <= l_data_d;
            l_valid_q   <= l_valid_d;
            r_data_q    <= r_data_d;
            r_valid_q   <= r_valid_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign l_in_ready     = grant_l;
    assign r_in_ready     = grant_r;
    assign l_out_data     = l_data_q;
    assign l_out_valid    = l_valid_q;
    assign r_out_data     = r_data_q;
    assign r_out_valid    = r_valid_q;
    assign fir_in_data    = fir_data_q;
    assign fir_in_valid   = fir_valid_q;
    assign fir_in_error   = 2'b00;
    assign err_sticky     = err_q;
    assign timeout_sticky = tmo_q;

endmodule
